// File: rtl/pmod_dac_pkg.sv
// Shared types and helpers for the multi-channel PMOD DAC driver.
package pmod_dac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap,
    StLdac
  } dac_state_e;

  localparam logic LDAC_PULSED = 1'b0;
  localparam logic LDAC_HOLD   = 1'b1;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pmod_dac_sclk_gen.sv
// SCLK generator: half-period counter and registered sclk, with edge strobes
// that mark the clock edge on which sclk is about to rise or fall.
module pmod_dac_sclk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic S_AXI_ACLK,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_sclk,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int unsigned CW = $clog2(CLK_DIV) + 1;

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_half_end;

  assign w_half_end  = i_en && (r_cnt == CW'(CLK_DIV - 1));
  assign o_rise_tick = w_half_end && !r_sclk;
  assign o_fall_tick = w_half_end && r_sclk;
  assign o_sclk      = r_sclk;

  // Clear wins over enable so the FSM can suppress the rise after the last bit.
  always_ff @(posedge S_AXI_ACLK or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_half_end) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pmod_dac_multi_spi.sv
// Multi-channel PMOD DAC driver: per-channel shadow registers, one shared
// SCLK/CS_N/LDAC_N and a DIN lane per channel, all shifted in parallel.
module pmod_dac_multi_spi import pmod_dac_pkg::*; #(
  parameter int unsigned RESOLUTION = 16,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned LDAC_W     = 2
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        rst,
  input  logic [RESOLUTION-1:0]       din,
  input  logic [ch_w(NUM_CH)-1:0]     din_ch,
  input  logic                        load_din,
  input  logic                        start,
  input  logic                        ldac_mode,
  output logic                        busy,
  output logic                        done,
  output logic                        dac_cs_n,
  output logic                        dac_ldac_n,
  output logic                        dac_sclk,
  output logic [NUM_CH-1:0]           dac_din
);

  localparam int unsigned CH_W   = ch_w(NUM_CH);
  localparam int unsigned PH_MAX = (CLK_DIV > LDAC_W) ? CLK_DIV : LDAC_W;
  localparam int unsigned PH_W   = $clog2(PH_MAX) + 1;
  localparam int unsigned BC_W   = $clog2(RESOLUTION) + 1;

  dac_state_e      r_state;
  logic [PH_W-1:0] r_phase;
  logic [BC_W-1:0] r_bit_cnt;
  logic            r_mode;
  logic            r_cs_n;
  logic            r_ldac_n;
  logic            r_busy;
  logic            r_done;

  logic w_accept;
  logic w_advance;
  logic w_bits_done;
  logic w_sclk_en;
  logic w_sclk_clr;
  logic w_rise_tick;
  logic w_fall_tick;

  assign w_accept    = (r_state == StIdle) && start;
  assign w_advance   = (r_state == StShift) && w_fall_tick;
  assign w_bits_done = (r_bit_cnt == BC_W'(RESOLUTION));
  // SETUP doubles as the first low half-period of SCLK.
  assign w_sclk_en   = (r_state == StSetup) || (r_state == StShift);
  assign w_sclk_clr  = !w_sclk_en || ((r_state == StShift) && w_bits_done && w_rise_tick);

  pmod_dac_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .S_AXI_ACLK (S_AXI_ACLK),
    .rst        (rst),
    .i_en       (w_sclk_en),
    .i_clr      (w_sclk_clr),
    .o_sclk     (dac_sclk),
    .o_rise_tick(w_rise_tick),
    .o_fall_tick(w_fall_tick)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [RESOLUTION-1:0] r_shadow;
    logic [RESOLUTION-1:0] r_shift;
    logic [RESOLUTION-1:0] w_snap;
    logic                  w_wr;

    // Out-of-range channel selects match no lane and are dropped.
    assign w_wr   = load_din && (din_ch == CH_W'(i));
    assign w_snap = w_wr ? din : r_shadow;

    always_ff @(posedge S_AXI_ACLK or posedge rst) begin
      if (rst) begin
        r_shadow <= '0;
      end else if (w_wr) begin
        r_shadow <= din;
      end
    end

    always_ff @(posedge S_AXI_ACLK or posedge rst) begin
      if (rst) begin
        r_shift <= '0;
      end else if (w_accept) begin
        r_shift <= w_snap;
      end else if (w_advance) begin
        r_shift <= r_shift << 1;
      end
    end

    assign dac_din[i] = r_shift[RESOLUTION-1];
  end

  always_ff @(posedge S_AXI_ACLK or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_phase   <= '0;
      r_bit_cnt <= '0;
      r_mode    <= LDAC_PULSED;
      r_cs_n    <= 1'b1;
      r_ldac_n  <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state   <= StSetup;
            r_mode    <= ldac_mode;
            r_cs_n    <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
            r_phase   <= '0;
          end
        end
        StSetup: begin
          if (w_rise_tick) begin
            r_state <= StShift;
          end
        end
        StShift: begin
          if (w_fall_tick) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          if (w_rise_tick && w_bits_done) begin
            r_state <= StHold;
            r_phase <= '0;
            if (r_mode == LDAC_HOLD) begin
              r_ldac_n <= 1'b0;
            end
          end
        end
        StHold: begin
          if (r_phase == PH_W'(CLK_DIV - 1)) begin
            r_phase <= '0;
            r_cs_n  <= 1'b1;
            r_state <= (r_mode == LDAC_HOLD) ? StLdac : StGap;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        StGap: begin
          if (r_phase == PH_W'(CLK_DIV - 1)) begin
            r_phase  <= '0;
            r_ldac_n <= 1'b0;
            r_state  <= StLdac;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        StLdac: begin
          if (r_phase == PH_W'(LDAC_W - 1)) begin
            r_phase  <= '0;
            r_ldac_n <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= StIdle;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign dac_cs_n   = r_cs_n;
  assign dac_ldac_n = r_ldac_n;

endmodule
